// File: rtl/arbitro_mux.sv
// Round-robin arbiter driving a shared 4:1 data mux, with a per-grant transfer quota.
// o_Valido and o_Salida are combinational: they follow the live request of the current owner.
module arbitro_mux #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] i_Req,
  input  logic [3:0] i_Datos_0,
  input  logic [3:0] i_Datos_1,
  input  logic [3:0] i_Datos_2,
  input  logic [3:0] i_Datos_3,
  input  logic       i_Listo,
  output logic [1:0] o_Sel,
  output logic [3:0] o_Grant,
  output logic [3:0] o_Salida,
  output logic       o_Valido
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  if (HOLD_MAX < 1 || HOLD_MAX > 7) begin : g_bad_hold_max
    $error("arbitro_mux: HOLD_MAX must be in 1..7");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [N_REQ-1:0]    grant_q, grant_d;

  logic [DATA_W-1:0]   datos [N_REQ];
  logic [SEL_W-1:0]    pick;
  logic [SEL_W-1:0]    cand;
  logic                found;
  logic                req_sel;
  logic                valido;
  logic                xfer;
  logic                quota;

  assign datos[0] = i_Datos_0;
  assign datos[1] = i_Datos_1;
  assign datos[2] = i_Datos_2;
  assign datos[3] = i_Datos_3;

  assign req_sel = i_Req[sel_q];
  assign valido  = (state_q == GRANT) && req_sel;
  assign xfer    = valido && i_Listo;
  assign quota   = xfer && (cnt_q == CNT_LAST);

  // First pending requester searching upward from the priority pointer, wrapping mod 4.
  always_comb begin
    pick  = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr_q + SEL_W'(i);
      if (!found && i_Req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // State register plus the registered datapath it owns.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
    end
  end

  // Next state: a withdrawal and a quota hit on the same edge collapse into one release.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = pick;
          grant_d = N_REQ'(1) << pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req_sel || quota) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = sel_q + SEL_W'(1);
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: registered select/grant, live valid and muxed data.
  always_comb begin
    o_Sel    = sel_q;
    o_Grant  = grant_q;
    o_Valido = valido;
    o_Salida = valido ? datos[sel_q] : '0;
  end

  a_grant_onehot0 : assert property (@(posedge i_Clk) disable iff (i_Reset)
    $onehot0(o_Grant));

  a_grant_matches_sel : assert property (@(posedge i_Clk) disable iff (i_Reset)
    (o_Grant != '0) |-> (o_Grant == (N_REQ'(1) << o_Sel)));

  a_grant_iff_state : assert property (@(posedge i_Clk) disable iff (i_Reset)
    (o_Grant != '0) == (state_q == GRANT));

endmodule

// File: tb/tb_arbitro_mux.sv
// Bench for arbitro_mux: quota-based reference model compared every cycle plus directed literal checks.
module tb_arbitro_mux;

  localparam int unsigned HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] datos [4];
  logic       listo;
  logic [1:0] sel;
  logic [3:0] grant;
  logic [3:0] salida;
  logic       valido;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arbitro_mux #(.HOLD_MAX(HOLD)) dut (
    .i_Clk     (clk),
    .i_Reset   (rst),
    .i_Req     (req),
    .i_Datos_0 (datos[0]),
    .i_Datos_1 (datos[1]),
    .i_Datos_2 (datos[2]),
    .i_Datos_3 (datos[3]),
    .i_Listo   (listo),
    .o_Sel     (sel),
    .o_Grant   (grant),
    .o_Salida  (salida),
    .o_Valido  (valido)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner plus remaining quota; released owner hands priority to the next index.
  bit armed   = 1'b0;
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_left  = 0;

  always @(posedge clk) begin
    if (rst) begin
      armed   = 1'b1;
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_left  = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        if (!m_busy && req[(m_ptr + k) % 4]) begin
          m_busy  = 1'b1;
          m_owner = (m_ptr + k) % 4;
          m_left  = HOLD;
        end
      end
    end else if (!req[m_owner]) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % 4;
    end else if (listo) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      bit exp_v;
      exp_v = m_busy && req[m_owner];
      check("model_grant",  int'(grant),  m_busy ? (1 << m_owner) : 0);
      check("model_sel",    int'(sel),    m_owner);
      check("model_valido", int'(valido), int'(exp_v));
      check("model_salida", int'(salida), exp_v ? int'(datos[m_owner]) : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    req      = 4'hF;
    listo    = 1'b1;
    datos[0] = 4'h1;
    datos[1] = 4'h5;
    datos[2] = 4'hA;
    datos[3] = 4'hC;

    // Reset held two cycles with all requests pending
    tick();
    tick();
    check("rst_grant",  int'(grant),  0);
    check("rst_sel",    int'(sel),    0);
    check("rst_valido", int'(valido), 0);
    check("rst_salida", int'(salida), 0);

    // Single requester 2, quota of four then one idle cycle
    rst = 1'b0;
    req = 4'b0100;
    tick();
    check("single_grant",  int'(grant),  4'b0100);
    check("single_sel",    int'(sel),    2);
    check("single_valido", int'(valido), 1);
    check("single_salida", int'(salida), 4'hA);
    repeat (3) tick();
    check("single_held3", int'(grant), 4'b0100);
    tick();
    check("single_release",   int'(grant),  0);
    check("single_idle_sel",  int'(sel),    2);
    check("single_idle_salida", int'(salida), 0);
    tick();
    check("single_regrant", int'(grant), 4'b0100);

    // Round robin with everyone requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_grant", int'(grant), 1 << (k % 4));
      repeat (3) tick();
      check("rr_held", int'(grant), 1 << (k % 4));
      tick();
      check("rr_idle", int'(grant), 0);
    end

    // Backpressure on requester 1
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    req   = 4'b0010;
    listo = 1'b0;
    tick();
    check("bp_grant", int'(grant), 4'b0010);
    repeat (20) tick();
    check("bp_held",   int'(grant),  4'b0010);
    check("bp_valido", int'(valido), 1);
    check("bp_salida", int'(salida), 4'h5);
    listo = 1'b1;
    repeat (3) tick();
    check("bp_after3", int'(grant), 4'b0010);
    tick();
    check("bp_release", int'(grant), 0);

    // Withdrawal by requester 3 after two transfers
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1000;
    tick();
    check("wd_grant", int'(grant), 4'b1000);
    check("wd_sel",   int'(sel),   3);
    tick();
    tick();
    req = 4'b0000;
    #1;
    check("wd_valido_drop", int'(valido), 0);
    check("wd_salida_drop", int'(salida), 0);
    check("wd_grant_kept",  int'(grant),  4'b1000);
    tick();
    check("wd_release", int'(grant), 0);
    req = 4'b1001;
    tick();
    check("wd_wrap_grant", int'(grant), 4'b0001);
    check("wd_wrap_sel",   int'(sel),   0);

    // Reset during requester 2's grant
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0100;
    tick();
    check("rm_grant", int'(grant), 4'b0100);
    tick();
    rst = 1'b1;
    tick();
    check("rm_grant0",  int'(grant),  0);
    check("rm_sel0",    int'(sel),    0);
    check("rm_valido0", int'(valido), 0);
    check("rm_salida0", int'(salida), 0);
    rst = 1'b0;
    req = 4'b1100;
    tick();
    check("rm_regrant", int'(grant), 4'b0100);
    check("rm_sel",     int'(sel),   2);
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
